data_mem: RTL and testbench

DATA_MEM -- requirements
Module: data_mem

---
 rtl/data_mem.sv | 165 ++++++++++++++++
 tb/tb_data_mem.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem.sv
// Byte-addressable data memory with a valid/ready request/response handshake.
// Responds LATENCY cycles after accept, with one outstanding request at most.
module data_mem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] memaddr,
    input  logic        memw,
    input  logic [1:0]  memwidth,
    input  logic        memsext,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] memdata,
    output logic        resp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, wr_q, sext_q;
    logic [1:0]  width_q, lane_q;
    logic [31:0] rdata_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic          accept;
    logic          req_err;
    logic          we;
    logic [AW-1:0] idx;
    logic [3:0]    be;
    logic [31:0]   wword;
    logic [31:0]   sh;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready && !reset;
    assign idx       = memaddr[AW+1:2];
    assign we        = accept && memw && !req_err;

    always_comb begin
        req_err = 1'b0;
        if (memwidth == 2'b11)
            req_err = 1'b1;
        if (memwidth == 2'b01 && memaddr[0])
            req_err = 1'b1;
        if (memwidth == 2'b10 && memaddr[1:0] != 2'b00)
            req_err = 1'b1;
        if ({2'b00, memaddr[31:2]} >= 32'(DEPTH_WORDS))
            req_err = 1'b1;
    end

    // Store data is replicated across lanes so the byte enables alone pick it.
    always_comb begin
        be    = 4'b0000;
        wword = wdata;
        case (memwidth)
            2'b00: begin
                be    = 4'b0001 << memaddr[1:0];
                wword = {4{wdata[7:0]}};
            end
            2'b01: begin
                be    = memaddr[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
            end
            2'b10: begin
                be    = 4'b1111;
                wword = wdata;
            end
            default: begin
                be    = 4'b0000;
                wword = wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && !memw && !req_err)
            rdata_q <= mem_q[idx];
        for (int k = 0; k < 4; k++) begin
            if (we && be[k])
                mem_q[idx][8*k +: 8] <= wword[8*k +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            sext_q  <= 1'b0;
            width_q <= 2'b00;
            lane_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                err_q   <= req_err;
                wr_q    <= memw;
                sext_q  <= memsext;
                width_q <= memwidth;
                lane_q  <= memaddr[1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY);
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                end
            end
            RESP: begin
                if (resp_ready)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid && err_q;
    assign sh         = rdata_q >> {lane_q, 3'b000};

    always_comb begin
        memdata = 32'd0;
        if (resp_valid && !err_q && !wr_q) begin
            case (width_q)
                2'b00:   memdata = {{24{sext_q & sh[7]}}, sh[7:0]};
                2'b01:   memdata = {{16{sext_q & sh[15]}}, sh[15:0]};
                2'b10:   memdata = rdata_q;
                default: memdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: directed scenarios on a LATENCY=0 and a LATENCY=3
// instance, plus random traffic against a byte-array reference model.
module tb_data_mem;

    localparam int D0 = 1024;
    localparam int D1 = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       reset = 2'b11;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [1:0][31:0] memaddr = '0;
    logic [1:0]       memw = '0;
    logic [1:0][1:0]  memwidth = '0;
    logic [1:0]       memsext = '0;
    logic [1:0][31:0] wdata = '0;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready = '0;
    logic [1:0][31:0] memdata;
    logic [1:0]       resp_err;

    int checks = 0;
    int failures = 0;
    logic [7:0] model [2][256];
    int depth [2] = '{D0, D1};
    int lat [2] = '{0, 3};

    data_mem #(.DEPTH_WORDS(D0), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .memaddr(memaddr[0]), .memw(memw[0]), .memwidth(memwidth[0]),
        .memsext(memsext[0]), .wdata(wdata[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .memdata(memdata[0]), .resp_err(resp_err[0])
    );

    data_mem #(.DEPTH_WORDS(D1), .LATENCY(3)) dut1 (
        .clk(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .memaddr(memaddr[1]), .memw(memw[1]), .memwidth(memwidth[1]),
        .memsext(memsext[1]), .wdata(wdata[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .memdata(memdata[1]), .resp_err(resp_err[1])
    );

    function automatic bit m_err(int d, logic [31:0] a, logic [1:0] wd);
        return (wd == 2'b11) || (wd == 2'b01 && a[0])
            || (wd == 2'b10 && a[1:0] != 2'b00)
            || ((a >> 2) >= 32'(depth[d]));
    endfunction

    function automatic logic [31:0] m_load(int d, logic [31:0] a,
                                           logic [1:0] wd, bit sx);
        int n = 1 << wd;
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++)
            v = v | (32'(model[d][int'(a[7:0]) + i]) << (8 * i));
        if (sx && n < 4 && v[8*n-1])
            v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic void m_store(int d, logic [31:0] a,
                                    logic [1:0] wd, logic [31:0] v);
        int n = 1 << wd;
        for (int i = 0; i < n; i++)
            model[d][int'(a[7:0]) + i] = v[8*i +: 8];
    endfunction

    // One full transaction; returns the response and cycles from accept.
    task automatic xact(input int d, input bit w, input logic [1:0] wd,
                        input bit sx, input logic [31:0] a,
                        input logic [31:0] wv, output logic [31:0] data,
                        output logic err, output int cyc,
                        output logic rdy_after);
        @(negedge clk);
        req_valid[d] = 1'b1;
        memw[d] = w;
        memwidth[d] = wd;
        memsext[d] = sx;
        memaddr[d] = a;
        wdata[d] = wv;
        resp_ready[d] = 1'b0;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        memaddr[d] = $urandom;
        wdata[d] = $urandom;
        memwidth[d] = 2'($urandom);
        memsext[d] = 1'($urandom);
        memw[d] = 1'($urandom);
        cyc = 1;
        while (!resp_valid[d] && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        data = memdata[d];
        err = resp_err[d];
        resp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[d] = 1'b0;
        rdy_after = req_ready[d] && !resp_valid[d];
    endtask

    task automatic test_reset();
        reset = 2'b11;
        req_valid = 2'b01;
        memw = 2'b01;
        memwidth[0] = 2'b10;
        memaddr[0] = 32'h10;
        wdata[0] = 32'h1111_1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 2'b00;
        req_valid = 2'b00;
        memw = 2'b00;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 ||
                memdata[d] !== 32'd0 || resp_err[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_state d%0d: rdy=%b vld=%b data=%h err=%b want 1 0 0 0",
                         d, req_ready[d], resp_valid[d], memdata[d], resp_err[d]);
            end
        end
    endtask

    task automatic test_word_roundtrip();
        logic [31:0] dat;
        logic er, ra;
        int cyc;
        xact(0, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, dat, er, cyc, ra);
        checks++;
        if (dat !== 32'd0 || er !== 1'b0 || cyc !== 1 || ra !== 1'b1) begin
            failures++;
            $display("FAIL word_store: data=%h err=%b cyc=%0d rdy=%b want 0 0 1 1",
                     dat, er, cyc, ra);
        end
        xact(0, 0, 2'b10, 0, 32'h10, 32'h0, dat, er, cyc, ra);
        checks++;
        if (dat !== 32'hDEAD_BEEF || er !== 1'b0 || cyc !== 1) begin
            failures++;
            $display("FAIL word_load: data=%h err=%b cyc=%0d want deadbeef 0 1",
                     dat, er, cyc);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] dat;
        logic er, ra;
        int cyc;
        xact(0, 1, 2'b00, 0, 32'h11, 32'hFFFF_FF80, dat, er, cyc, ra);
        xact(0, 0, 2'b00, 1, 32'h11, 32'h0, dat, er, cyc, ra);
        checks++;
        if (dat !== 32'hFFFF_FF80 || er !== 1'b0) begin
            failures++;
            $display("FAIL byte_sext: data=%h err=%b want ffffff80 0", dat, er);
        end
        xact(0, 0, 2'b00, 0, 32'h11, 32'h0, dat, er, cyc, ra);
        checks++;
        if (dat !== 32'h0000_0080 || er !== 1'b0) begin
            failures++;
            $display("FAIL byte_zext: data=%h err=%b want 00000080 0", dat, er);
        end
        xact(0, 0, 2'b01, 1, 32'h12, 32'h0, dat, er, cyc, ra);
        checks++;
        if (dat !== 32'hFFFF_DEAD || er !== 1'b0) begin
            failures++;
            $display("FAIL half_sext: data=%h err=%b want ffffdead 0", dat, er);
        end
        xact(0, 0, 2'b10, 1, 32'h10, 32'h0, dat, er, cyc, ra);
        checks++;
        if (dat !== 32'hDEAD_80EF || er !== 1'b0) begin
            failures++;
            $display("FAIL word_after_byte: data=%h err=%b want dead80ef 0", dat, er);
        end
    endtask

    task automatic test_errors();
        logic [31:0] dat;
        logic er, ra;
        int cyc;
        logic [31:0] ea [4] = '{32'h13, 32'h12, 32'h10, 32'(4 * D0)};
        logic [1:0]  ew [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
        bit          es [4] = '{0, 1, 0, 0};
        for (int i = 0; i < 4; i++) begin
            xact(0, es[i], ew[i], 1, ea[i], 32'h5555_5555, dat, er, cyc, ra);
            checks++;
            if (er !== 1'b1 || dat !== 32'd0 || cyc !== 1 || ra !== 1'b1) begin
                failures++;
                $display("FAIL error_%0d: err=%b data=%h cyc=%0d want 1 0 1",
                         i, er, dat, cyc);
            end
        end
        xact(0, 0, 2'b10, 0, 32'h10, 32'h0, dat, er, cyc, ra);
        checks++;
        if (dat !== 32'hDEAD_80EF || er !== 1'b0) begin
            failures++;
            $display("FAIL error_no_write: data=%h err=%b want dead80ef 0", dat, er);
        end
        xact(0, 1, 2'b10, 0, 32'(4 * D0 - 4), 32'h0BAD_CAFE, dat, er, cyc, ra);
        xact(0, 0, 2'b10, 0, 32'(4 * D0 - 4), 32'h0, dat, er, cyc, ra);
        checks++;
        if (dat !== 32'h0BAD_CAFE || er !== 1'b0) begin
            failures++;
            $display("FAIL top_word: data=%h err=%b want 0badcafe 0", dat, er);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] dat;
        logic er, ra;
        int cyc;
        bit bad_rdy, bad_hold;
        xact(1, 1, 2'b10, 0, 32'h40, 32'hCAFE_F00D, dat, er, cyc, ra);
        @(negedge clk);
        req_valid[1] = 1'b1;
        memw[1] = 1'b0;
        memwidth[1] = 2'b10;
        memaddr[1] = 32'h40;
        resp_ready[1] = 1'b0;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        memaddr[1] = 32'h0;
        cyc = 1;
        bad_rdy = 1'b0;
        while (!resp_valid[1] && cyc < 40) begin
            if (req_ready[1]) bad_rdy = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        checks++;
        if (cyc !== 4) begin
            failures++;
            $display("FAIL lat3_rise: cycles=%0d want 4", cyc);
        end
        bad_hold = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (!resp_valid[1] || memdata[1] !== 32'hCAFE_F00D || resp_err[1])
                bad_hold = 1'b1;
            if (req_ready[1]) bad_rdy = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad_hold) begin
            failures++;
            $display("FAIL hold_resp: data=%h vld=%b want cafef00d 1",
                     memdata[1], resp_valid[1]);
        end
        checks++;
        if (bad_rdy) begin
            failures++;
            $display("FAIL busy_ready: req_ready seen 1 want 0");
        end
        resp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        resp_ready[1] = 1'b0;
        checks++;
        if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0) begin
            failures++;
            $display("FAIL release: rdy=%b vld=%b want 1 0",
                     req_ready[1], resp_valid[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] dat;
        logic er, ra;
        int cyc;
        bit seen;
        xact(1, 1, 2'b10, 0, 32'h20, 32'hA5A5_A5A5, dat, er, cyc, ra);
        @(negedge clk);
        req_valid[1] = 1'b1;
        memw[1] = 1'b0;
        memwidth[1] = 2'b10;
        memaddr[1] = 32'h20;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        reset[1] = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0) begin
            failures++;
            $display("FAIL reset_wait: rdy=%b vld=%b want 1 0",
                     req_ready[1], resp_valid[1]);
        end
        @(negedge clk);
        reset[1] = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (resp_valid[1]) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL discarded_resp: resp_valid=1 want 0");
        end
        @(negedge clk);
        reset[1] = 1'b1;
        req_valid[1] = 1'b1;
        memw[1] = 1'b1;
        memwidth[1] = 2'b10;
        memaddr[1] = 32'h20;
        wdata[1] = 32'h1234_5678;
        @(negedge clk);
        reset[1] = 1'b0;
        req_valid[1] = 1'b0;
        memw[1] = 1'b0;
        xact(1, 0, 2'b10, 0, 32'h20, 32'h0, dat, er, cyc, ra);
        checks++;
        if (dat !== 32'hA5A5_A5A5 || er !== 1'b0) begin
            failures++;
            $display("FAIL store_in_reset: data=%h err=%b want a5a5a5a5 0", dat, er);
        end
    endtask

    task automatic test_random(input int d, input int n);
        logic [31:0] dat, a, v, exp;
        logic er, ra;
        logic [1:0] wd;
        bit w, sx, eexp;
        int cyc;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            xact(d, 1, 2'b10, 0, 32'(4 * i), v, dat, er, cyc, ra);
            m_store(d, 32'(4 * i), 2'b10, v);
            checks++;
            if (er !== 1'b0 || cyc !== 1 + lat[d]) begin
                failures++;
                $display("FAIL rand_init d%0d i%0d: err=%b cyc=%0d want 0 %0d",
                         d, i, er, cyc, 1 + lat[d]);
            end
        end
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0)
                a = ($urandom_range(0, 1) == 0) ? 32'(4 * depth[d]) + $urandom_range(0, 99)
                                                : $urandom;
            else
                a = $urandom_range(0, 255);
            wd = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            w = 1'($urandom);
            sx = 1'($urandom);
            v = $urandom;
            eexp = m_err(d, a, wd);
            exp = 32'd0;
            if (!eexp && !w) exp = m_load(d, a, wd, sx);
            xact(d, w, wd, sx, a, v, dat, er, cyc, ra);
            if (!eexp && w) m_store(d, a, wd, v);
            checks++;
            if (dat !== exp || er !== eexp || cyc !== 1 + lat[d] || ra !== 1'b1) begin
                failures++;
                $display("FAIL rand d%0d #%0d a=%h w=%b wd=%0d: data=%h err=%b cyc=%0d rdy=%b want %h %b %0d 1",
                         d, i, a, w, wd, dat, er, cyc, ra, exp, eexp, 1 + lat[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word_roundtrip();
        test_byte_lanes();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_random(0, 300);
        test_random(1, 200);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
